// File: rtl/pipeline_stall_unit.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_stall_unit
// Brief   : Load-use / data-memory-wait hazard unit with timeout and
//           saturating stall-cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_stall_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rs1_address_id_stage,
  input  logic [4:0]           rs2_address_id_stage,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  input  logic [4:0]           destination_address_alu_stage,
  input  logic                 mem_read_alu_stage,
  input  logic                 data_mem_busy,
  input  logic                 branch_taken,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 id_alu_bubble,
  output logic                 if_id_flush,
  output logic                 alu_mem_stall,
  output logic                 mem_timeout_error,
  output logic [CNT_WIDTH-1:0] stall_cycle_count
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MEM_WAIT   = 2'd2,
    S_ERROR      = 2'd3
  } state_t;

  localparam logic [7:0]           c_mem_timeout = 8'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max     = '1;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one     = CNT_WIDTH'(1);

  state_t               r_state, w_state_next;
  logic [7:0]           r_wait_cnt, w_wait_cnt_next;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  logic w_hazard;
  logic w_pc_stall, w_if_id_stall, w_bubble, w_flush, w_alu_mem_stall, w_error;

  assign w_hazard = mem_read_alu_stage
                  && (destination_address_alu_stage != 5'd0)
                  && ((rs1_used && (destination_address_alu_stage == rs1_address_id_stage))
                   || (rs2_used && (destination_address_alu_stage == rs2_address_id_stage)));

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_pc_stall      = 1'b0;
    w_if_id_stall   = 1'b0;
    w_bubble        = 1'b0;
    w_flush         = 1'b0;
    w_alu_mem_stall = 1'b0;
    w_error         = 1'b0;
    case (r_state)
      S_RUN, S_LOAD_STALL: begin
        // The load is already in MEM during LOAD_STALL, so no hazard re-check there.
        if (r_state == S_LOAD_STALL) w_state_next = S_RUN;
        if (data_mem_busy) begin
          w_pc_stall      = 1'b1;
          w_if_id_stall   = 1'b1;
          w_alu_mem_stall = 1'b1;
          w_wait_cnt_next = 8'd1;
          w_state_next    = S_MEM_WAIT;
        end else if (branch_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (w_hazard && (r_state == S_RUN)) begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_bubble      = 1'b1;
          w_state_next  = S_LOAD_STALL;
        end
      end
      S_MEM_WAIT: begin
        if (data_mem_busy) begin
          w_pc_stall      = 1'b1;
          w_if_id_stall   = 1'b1;
          w_alu_mem_stall = 1'b1;
          w_wait_cnt_next = r_wait_cnt + 8'd1;
          if ((r_wait_cnt + 8'd1) == c_mem_timeout) w_state_next = S_ERROR;
        end else begin
          w_wait_cnt_next = 8'd0;
          w_state_next    = S_RUN;
        end
      end
      S_ERROR: begin
        w_pc_stall      = 1'b1;
        w_if_id_stall   = 1'b1;
        w_alu_mem_stall = 1'b1;
        w_error         = 1'b1;
      end
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= 8'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_pc_stall && (r_stall_cnt != c_cnt_max)) r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  // Gate with reset so a mid-stall reset leaves no residual freeze from live inputs.
  assign pc_stall          = reset & w_pc_stall;
  assign if_id_stall       = reset & w_if_id_stall;
  assign id_alu_bubble     = reset & w_bubble;
  assign if_id_flush       = reset & w_flush;
  assign alu_mem_stall     = reset & w_alu_mem_stall;
  assign mem_timeout_error = reset & w_error;
  assign stall_cycle_count = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_stall_unit
// Brief   : Self-checking bench; two DUT configurations against a cycle model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       rs1_used, rs2_used, mem_read, busy, branch;

  logic       d0_pc, d0_ifid, d0_bub, d0_flush, d0_alu, d0_err;
  logic       d1_pc, d1_ifid, d1_bub, d1_flush, d1_alu, d1_err;
  logic [15:0] d0_cnt;
  logic [3:0]  d1_cnt;

  int checks = 0;
  int failures = 0;

  // Model state per configuration: 0 = defaults, 1 = MEM_TIMEOUT 4 / CNT_WIDTH 4
  int      busy_len[2];
  bit      timed_out[2];
  bit      stalled_last[2];
  longint  total[2];
  int      tmo[2]  = '{16, 4};
  longint  cmax[2] = '{65535, 15};
  logic [5:0] exp_ctl[2];
  longint  saved;

  always #5 clk = ~clk;

  pipeline_stall_unit dut0 (
    .clk(clk), .reset(reset),
    .rs1_address_id_stage(rs1), .rs2_address_id_stage(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .destination_address_alu_stage(rd), .mem_read_alu_stage(mem_read),
    .data_mem_busy(busy), .branch_taken(branch),
    .pc_stall(d0_pc), .if_id_stall(d0_ifid), .id_alu_bubble(d0_bub),
    .if_id_flush(d0_flush), .alu_mem_stall(d0_alu),
    .mem_timeout_error(d0_err), .stall_cycle_count(d0_cnt)
  );

  pipeline_stall_unit #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .reset(reset),
    .rs1_address_id_stage(rs1), .rs2_address_id_stage(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .destination_address_alu_stage(rd), .mem_read_alu_stage(mem_read),
    .data_mem_busy(busy), .branch_taken(branch),
    .pc_stall(d1_pc), .if_id_stall(d1_ifid), .id_alu_bubble(d1_bub),
    .if_id_flush(d1_flush), .alu_mem_stall(d1_alu),
    .mem_timeout_error(d1_err), .stall_cycle_count(d1_cnt)
  );

  wire [5:0] d0_ctl = {d0_pc, d0_ifid, d0_bub, d0_flush, d0_alu, d0_err};
  wire [5:0] d1_ctl = {d1_pc, d1_ifid, d1_bub, d1_flush, d1_alu, d1_err};

  function automatic bit hazard_now();
    return mem_read && (rd != 0)
        && ((rs1_used && rd == rs1) || (rs2_used && rd == rs2));
  endfunction

  // Control vector {pc, ifid, bubble, flush, alu_mem, error}
  function automatic logic [5:0] model_ctl(int k);
    if (timed_out[k])                     return 6'b110011;
    if (busy)                             return 6'b110010;
    if (busy_len[k] > 0)                  return 6'b000000;
    if (branch)                           return 6'b001100;
    if (hazard_now() && !stalled_last[k]) return 6'b111000;
    return 6'b000000;
  endfunction

  function automatic longint sat(int k);
    return (total[k] > cmax[k]) ? cmax[k] : total[k];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      busy_len[k] = 0; timed_out[k] = 0; stalled_last[k] = 0; total[k] = 0;
    end
  endtask

  task automatic model_edge(int k, logic [5:0] ctl);
    if (ctl[5]) total[k]++;
    stalled_last[k] = (ctl == 6'b111000);
    if (!timed_out[k]) begin
      if (busy) begin
        busy_len[k]++;
        if (busy_len[k] >= tmo[k]) timed_out[k] = 1;
      end else begin
        busy_len[k] = 0;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare one cycle at the falling edge, then advance the model on the rising edge.
  task automatic cycle(string tag);
    exp_ctl[0] = model_ctl(0);
    exp_ctl[1] = model_ctl(1);
    @(negedge clk);
    check({tag, "_ctl0"}, 32'(d0_ctl), 32'(exp_ctl[0]));
    check({tag, "_ctl1"}, 32'(d1_ctl), 32'(exp_ctl[1]));
    check({tag, "_cnt0"}, 32'(d0_cnt), 32'(sat(0)));
    check({tag, "_cnt1"}, 32'(d1_cnt), 32'(sat(1)));
    @(posedge clk);
    model_edge(0, exp_ctl[0]);
    model_edge(1, exp_ctl[1]);
    #1;
  endtask

  task automatic async_reset(string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, "_rst_ctl0"}, 32'(d0_ctl), 32'd0);
    check({tag, "_rst_ctl1"}, 32'(d1_ctl), 32'd0);
    check({tag, "_rst_cnt0"}, 32'(d0_cnt), 32'd0);
    check({tag, "_rst_cnt1"}, 32'(d1_cnt), 32'd0);
    model_clear();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0;
    mem_read = 0; busy = 0; branch = 0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    model_clear();
    #1;
    check("reset_ctl0", 32'(d0_ctl), 32'd0);
    check("reset_cnt0", 32'(d0_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    cycle("idle");

    // Load-use hazard
    rd = 5; mem_read = 1; rs1 = 5; rs1_used = 1;
    cycle("t1_stall");
    mem_read = 0;
    cycle("t1_after");
    check("t1_count", 32'(d0_cnt), 32'd1);

    // Masked cases
    idle(); rd = 0; rs1 = 0; rs1_used = 1; mem_read = 1;
    cycle("t2_x0");
    idle(); rd = 7; rs2 = 7; rs2_used = 0; mem_read = 1;
    cycle("t2_unused");
    idle(); rd = 7; rs2 = 7; rs2_used = 1; mem_read = 0;
    cycle("t2_noload");

    // Memory wait of four cycles
    idle();
    async_reset("t3");
    saved = total[0];
    busy = 1;
    for (int i = 0; i < 4; i++) cycle("t3_busy");
    busy = 0;
    cycle("t3_release");
    check("t3_delta", 32'(d0_cnt), 32'd4);
    check("t3_err0", 32'(d0_err), 32'd0);

    // Timeout on the MEM_TIMEOUT=4 instance
    async_reset("t4a");
    busy = 1;
    for (int i = 0; i < 5; i++) cycle("t4_busy");
    busy = 0;
    cycle("t4_hold");
    cycle("t4_hold");
    check("t4_err1", 32'(d1_err), 32'd1);
    check("t4_stall1", 32'({d1_pc, d1_ifid, d1_alu}), 32'h7);
    async_reset("t4b");

    // Priority
    rd = 5; mem_read = 1; rs1 = 5; rs1_used = 1; branch = 1;
    cycle("t5_branch");
    busy = 1;
    cycle("t5_all");
    busy = 0; branch = 0;
    cycle("t5_release");
    cycle("t5_rehazard");
    idle();
    cycle("t5_idle");

    // Counter saturation on the CNT_WIDTH=4 instance
    async_reset("t6");
    busy = 1;
    for (int i = 0; i < 20; i++) cycle("t6_busy");
    busy = 0;
    check("t6_sat1", 32'(d1_cnt), 32'd15);
    async_reset("t6b");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rd       = 5'($urandom_range(0, 3));
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      rs1_used = 1'($urandom_range(0, 1));
      rs2_used = 1'($urandom_range(0, 1));
      mem_read = 1'($urandom_range(0, 1));
      branch   = ($urandom_range(0, 5) == 0);
      busy     = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 39) == 0) async_reset("rnd");
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
